bbq_resp_monitor: RTL



---
 rtl/bbq_resp_monitor_pkg.sv | 45 ++++
 rtl/bbq_mon_prio_fifo.sv | 68 ++++++
 rtl/bbq_resp_monitor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bbq_resp_monitor_pkg.sv
// ---------------------------------------------------------------------------
// heap_ops: shared BBQ heap types.
//   heap_op_t   - request/response operation type driven into and out of bbq.
//   mon_err_t   - error codes reported by bbq_resp_monitor. Lower code wins
//                 when several errors fire in the same cycle.
//   mon_state_t - bbq_resp_monitor control states.
//   mon_first_err() - picks the lowest-numbered raised error flag.
// ---------------------------------------------------------------------------
package heap_ops;

  typedef enum logic [1:0] {
    HEAP_OP_ENQUE     = 2'd0,
    HEAP_OP_DEQUE_MIN = 2'd1,
    HEAP_OP_DEQUE_MAX = 2'd2
  } heap_op_t;

  typedef enum logic [2:0] {
    MON_ERR_NONE          = 3'd0,
    MON_ERR_SIZE_MISMATCH = 3'd1,
    MON_ERR_ORDER         = 3'd2,
    MON_ERR_UNDERFLOW     = 3'd3,
    MON_ERR_SPURIOUS      = 3'd4,
    MON_ERR_TIMEOUT       = 3'd5,
    MON_ERR_OVERFLOW      = 3'd6
  } mon_err_t;

  typedef enum logic [1:0] {
    MON_INIT = 2'd0,
    MON_RUN  = 2'd1,
    MON_FAIL = 2'd2
  } mon_state_t;

  localparam int unsigned MON_FIFO_DEPTH = 256;

  // flags[k] set means error code k fired this cycle.
  function automatic mon_err_t mon_first_err(input logic [6:1] flags);
    mon_err_t code;
    code = MON_ERR_NONE;
    for (int i = 6; i >= 1; i--) begin
      if (flags[i]) code = mon_err_t'(3'(i));
    end
    return code;
  endfunction

endpackage

// File: rtl/bbq_mon_prio_fifo.sv
// ---------------------------------------------------------------------------
// bbq_mon_prio_fifo: 256-deep FIFO of enqueue-request priorities, so each
// ENQUE response can be paired with the priority of the request it answers.
// Ports:
//   user_clk, arst (sync, active-high), clear (sync soft clear)
//   push/push_prio - store an enqueue request priority (dropped when full)
//   pop            - discard the head entry (ignored when empty)
//   pop_prio       - head entry, valid while !empty
//   empty          - no stored entries
// ---------------------------------------------------------------------------
module bbq_mon_prio_fifo
  import heap_ops::*;
#(
  parameter int unsigned PW    = 15,
  parameter int unsigned DEPTH = MON_FIFO_DEPTH
) (
  input  logic          user_clk,
  input  logic          arst,
  input  logic          clear,
  input  logic          push,
  input  logic [PW-1:0] push_prio,
  input  logic          pop,
  output logic [PW-1:0] pop_prio,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge user_clk) begin
    if (arst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge user_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_prio;
  end

  assign pop_prio = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);

endmodule

// File: rtl/bbq_resp_monitor.sv
// ---------------------------------------------------------------------------
// bbq_resp_monitor: response-side checker for the BBQ heap. Tracks shadow
// occupancy, outstanding requests and a dequeue-order floor, and latches the
// first protocol/ordering violation.
// Ports:
//   user_clk, arst (sync, active-high), clear (sync soft clear, same as arst)
//   heap_ready                          - BBQ init done, INIT -> RUN
//   req_valid/req_op_type/req_priority  - request accepted by bbq
//   resp_valid/resp_op_type/resp_priority/resp_size - bbq output stream
//   err, err_code                       - sticky error flag and first code
//   enq_count, deq_count                - completed operations, wrapping
//   running                             - monitor is in RUN
// Build option: BBQ_MON_WATCHDOG_EN adds an idle watchdog raising TIMEOUT.
// ---------------------------------------------------------------------------
module bbq_resp_monitor
  import heap_ops::*;
#(
  parameter  int unsigned HEAP_BITMAP_WIDTH    = 32,
  parameter  int unsigned NB_LEVELS            = 3,
  parameter  int unsigned HEAP_ENTRY_DWIDTH    = 17,
  parameter  int unsigned HEAP_MAX_NUM_ENTRIES = (1 << 17) - 1,
  parameter  int unsigned TIMEOUT_CYCLES       = 1024,
  localparam int unsigned PW = $clog2(HEAP_BITMAP_WIDTH ** NB_LEVELS),
  localparam int unsigned SW = $clog2(HEAP_MAX_NUM_ENTRIES)
) (
  input  logic          user_clk,
  input  logic          arst,
  input  logic          heap_ready,
  input  logic          req_valid,
  input  heap_op_t      req_op_type,
  input  logic [PW-1:0] req_priority,
  input  logic          resp_valid,
  input  heap_op_t      resp_op_type,
  input  logic [PW-1:0] resp_priority,
  input  logic [SW-1:0] resp_size,
  input  logic          clear,
  output logic          err,
  output mon_err_t      err_code,
  output logic [31:0]   enq_count,
  output logic [31:0]   deq_count,
  output logic          running
);

  localparam logic [SW-1:0] SHADOW_MAX = SW'(HEAP_MAX_NUM_ENTRIES);

  mon_state_t    state_q, state_d;
  logic [7:0]    outst_q, outst_d;
  logic [SW-1:0] shadow_q, shadow_d;
  logic [PW-1:0] floor_q, floor_d;
  logic          err_q, err_d;
  mon_err_t      err_code_q, err_code_d;
  logic [31:0]   enq_count_q, enq_count_d;
  logic [31:0]   deq_count_q, deq_count_d;
  logic          running_q, running_d;

  logic [6:1]    flags;
  logic          fifo_push, fifo_pop, fifo_empty;
  logic [PW-1:0] fifo_prio, enq_prio;

`ifdef BBQ_MON_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] idle_q, idle_d;
`else
  // The watchdog limit has no consumer when the watchdog is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  bbq_mon_prio_fifo #(
    .PW    (PW),
    .DEPTH (MON_FIFO_DEPTH)
  ) u_prio_fifo (
    .user_clk  (user_clk),
    .arst      (arst),
    .clear     (clear),
    .push      (fifo_push),
    .push_prio (req_priority),
    .pop       (fifo_pop),
    .pop_prio  (fifo_prio),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    outst_d     = outst_q;
    shadow_d    = shadow_q;
    floor_d     = floor_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    enq_count_d = enq_count_q;
    deq_count_d = deq_count_q;
    flags       = '0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    enq_prio    = '0;
`ifdef BBQ_MON_WATCHDOG_EN
    idle_d      = idle_q;
`endif

    unique case (state_q)
      MON_INIT: begin
        if (req_valid || resp_valid) flags[MON_ERR_SPURIOUS] = 1'b1;
        else if (heap_ready)         state_d = MON_RUN;
      end

      MON_RUN: begin
        // A response is legal with nothing outstanding only if a request lands in the same cycle.
        if (resp_valid && (outst_q == '0) && !req_valid) flags[MON_ERR_SPURIOUS] = 1'b1;
        if (req_valid && !resp_valid && (outst_q == 8'hFF)) flags[MON_ERR_OVERFLOW] = 1'b1;
        outst_d   = outst_q + 8'(req_valid) - 8'(resp_valid);
        fifo_push = req_valid && (req_op_type == HEAP_OP_ENQUE);

        if (resp_valid) begin
          if (resp_op_type == HEAP_OP_ENQUE) begin
            // Pair with the oldest enqueue request; fall back to the bbq-reported priority.
            fifo_pop = !fifo_empty;
            enq_prio = fifo_empty ? resp_priority : fifo_prio;
            if (shadow_q == SHADOW_MAX) flags[MON_ERR_OVERFLOW] = 1'b1;
            else                        shadow_d = shadow_q + SW'(1);
            if (enq_prio < floor_q) floor_d = enq_prio;
            enq_count_d = enq_count_q + 32'd1;
          end else if (resp_op_type == HEAP_OP_DEQUE_MIN) begin
            if (shadow_q == '0) flags[MON_ERR_UNDERFLOW] = 1'b1;
            else                shadow_d = shadow_q - SW'(1);
            if (resp_priority < floor_q) flags[MON_ERR_ORDER] = 1'b1;
            else                         floor_d = resp_priority;
            deq_count_d = deq_count_q + 32'd1;
          end
          if (resp_size != shadow_d) flags[MON_ERR_SIZE_MISMATCH] = 1'b1;
        end

`ifdef BBQ_MON_WATCHDOG_EN
        if (resp_valid)           idle_d = '0;
        else if (outst_q != '0) begin
          idle_d = idle_q + 16'd1;
          if (idle_d >= TIMEOUT_LIM) flags[MON_ERR_TIMEOUT] = 1'b1;
        end else                  idle_d = '0;
`endif
      end

      MON_FAIL: ;

      default: state_d = MON_INIT;
    endcase

    if (flags != '0) begin
      state_d    = MON_FAIL;
      err_d      = 1'b1;
      err_code_d = mon_first_err(flags);
    end

    running_d = (state_d == MON_RUN);
  end

  always_ff @(posedge user_clk) begin
    if (arst || clear) begin
      state_q     <= MON_INIT;
      outst_q     <= '0;
      shadow_q    <= '0;
      floor_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= MON_ERR_NONE;
      enq_count_q <= '0;
      deq_count_q <= '0;
      running_q   <= 1'b0;
`ifdef BBQ_MON_WATCHDOG_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      outst_q     <= outst_d;
      shadow_q    <= shadow_d;
      floor_q     <= floor_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      enq_count_q <= enq_count_d;
      deq_count_q <= deq_count_d;
      running_q   <= running_d;
`ifdef BBQ_MON_WATCHDOG_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign err       = err_q;
  assign err_code  = err_code_q;
  assign enq_count = enq_count_q;
  assign deq_count = deq_count_q;
  assign running   = running_q;

endmodule
